// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; anode codes are active-low.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Position of the most significant nonzero nibble; an all-zero word maps to
    // digit 0 so the rightmost digit always survives leading-zero blanking.
    function automatic logic [1:0] top_digit(input logic [15:0] word);
        logic [1:0] top;
        top = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (word[k*4 +: 4] != 4'h0) top = 2'(k);
        end
        return top;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-slot blanking,
// frame-synchronous value snapshot and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        ClkIn,
    input  logic        Rst,
    input  logic [15:0] Value,
    input  logic [3:0]  DigitEn,
    input  logic [3:0]  DpIn,
    input  logic        LeadZeroBlank,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  An,
    output logic        ScanTick
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] prescaler;
    logic [1:0]    digit_idx;
    logic [15:0]   snapshot;
    logic          lzb_q;

    logic          slot_wrap;
    logic          frame_wrap;
    logic          in_blank;
    logic          suppressed;
    logic [3:0]    cur_nibble;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          dp_next;

    assign slot_wrap  = (prescaler == PW'(REFRESH_DIV - 1));
    assign frame_wrap = slot_wrap && (digit_idx == 2'd3);
    assign in_blank   = (prescaler < PW'(BLANK_CYCLES));
    assign cur_nibble = snapshot[digit_idx*4 +: 4];

    // Enables and decimal points are live; the blanking decision uses the frame snapshot.
    assign suppressed = !DigitEn[digit_idx] || (lzb_q && (digit_idx > top_digit(snapshot)));

    hex_to_seg7 u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!in_blank && !suppressed) begin
            an_next  = AN_OFF & ~(4'b0001 << digit_idx);
            seg_next = dec_seg;
            dp_next  = ~DpIn[digit_idx];
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            prescaler <= '0;
            digit_idx <= 2'd0;
            snapshot  <= 16'h0000;
            lzb_q     <= 1'b0;
            ScanTick  <= 1'b0;
            An        <= AN_OFF;
            Seg       <= SEG_OFF;
            Dp        <= 1'b1;
        end else begin
            prescaler <= slot_wrap ? '0 : prescaler + 1'b1;
            if (slot_wrap) digit_idx <= digit_idx + 2'd1;
            if (frame_wrap) begin
                snapshot <= Value;
                lzb_q    <= LeadZeroBlank;
            end
            ScanTick <= frame_wrap;
            An       <= an_next;
            Seg      <= seg_next;
            Dp       <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: a cycle-indexed reference model predicts every output
// from elapsed cycles since reset, a per-frame snapshot and the live inputs.
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        ClkIn = 1'b0;
    logic        Rst;
    logic [15:0] Value;
    logic [3:0]  DigitEn;
    logic [3:0]  DpIn;
    logic        LeadZeroBlank;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  An;
    logic        ScanTick;

    seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .ClkIn         (ClkIn),
        .Rst           (Rst),
        .Value         (Value),
        .DigitEn       (DigitEn),
        .DpIn          (DpIn),
        .LeadZeroBlank (LeadZeroBlank),
        .Seg           (Seg),
        .Dp            (Dp),
        .An            (An),
        .ScanTick      (ScanTick)
    );

    always #5 ClkIn = ~ClkIn;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          k;            // clock edges since reset release
    logic [15:0] m_snap;
    logic        m_lzb;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s at t=%0t cycle=%0d: got %h expected %h", tag, $time, k, observed, expected);
        end
    endtask

    // One clock edge: predict outputs from the cycle number, then compare on the falling edge.
    task automatic step();
        int   slot_pos;
        int   digit;
        int   top;
        bit   lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_tick;
        @(posedge ClkIn);
        slot_pos = k % DIV;
        digit    = (k / DIV) % 4;
        top      = 0;
        for (int d = 0; d < 4; d++) if (((m_snap >> (4*d)) & 16'hF) != 0) top = d;
        lit = (slot_pos >= BLANK) && DigitEn[digit] && !(m_lzb && digit > top);
        e_an   = lit ? ~(4'b0001 << digit) : 4'b1111;
        e_seg  = lit ? seg_tab[(m_snap >> (4*digit)) & 16'hF] : 7'b1111111;
        e_dp   = lit ? ~DpIn[digit] : 1'b1;
        e_tick = (k % FRAME) == FRAME - 1;
        if ((k % FRAME) == FRAME - 1) begin
            m_snap = Value;
            m_lzb  = LeadZeroBlank;
        end
        @(negedge ClkIn);
        check("an", 32'(An), 32'(e_an));
        check("seg", 32'(Seg), 32'(e_seg));
        check("dp", 32'(Dp), 32'(e_dp));
        check("tick", 32'(ScanTick), 32'(e_tick));
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        k      = 0;
        m_snap = 16'h0000;
        m_lzb  = 1'b0;
    endtask

    initial begin
        int seen;
        int period;
        Rst           = 1'b1;
        Value         = 16'h1234;
        DigitEn       = 4'b1111;
        DpIn          = 4'b0000;
        LeadZeroBlank = 1'b0;
        model_reset();
        repeat (3) @(negedge ClkIn);
        check("rst_an", 32'(An), 32'hF);
        check("rst_seg", 32'(Seg), 32'h7F);
        check("rst_dp", 32'(Dp), 32'h1);
        check("rst_tick", 32'(ScanTick), 32'h0);
        Rst = 1'b0;

        // First frame shows zeros, then 1234.
        run(2 * FRAME);

        // ScanTick spacing, with a bounded search for the first pulse.
        seen = 0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            step();
            if (ScanTick) seen = 1;
        end
        check("tick_seen", 32'(seen), 32'h1);
        period = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            period++;
            if (ScanTick) break;
        end
        check("tick_period", 32'(period), 32'(FRAME));

        // Leading-zero blanking.
        Value = 16'h0050; LeadZeroBlank = 1'b1;
        run(2 * FRAME);
        Value = 16'h0000;
        run(2 * FRAME);

        // Enables and decimal points.
        Value = 16'h1234; LeadZeroBlank = 1'b0; DigitEn = 4'b1010; DpIn = 4'b0010;
        run(2 * FRAME);

        // Mid-frame value change must not tear.
        DigitEn = 4'b1111; DpIn = 4'b0000; Value = 16'hAAAA;
        run(2 * FRAME);
        for (int i = 0; i < FRAME && (k % FRAME) != DIV + DIV/2; i++) step();
        Value = 16'h5555;
        run(2 * FRAME);

        // Randomised inputs, changed at random points within frames.
        for (int r = 0; r < 40; r++) begin
            Value         = 16'($urandom);
            DigitEn       = 4'($urandom);
            DpIn          = 4'($urandom);
            LeadZeroBlank = 1'($urandom);
            if ($urandom_range(0, 3) == 0) Value = Value & 16'h00FF;
            run($urandom_range(1, 40));
        end

        // Asynchronous reset in the middle of a DRIVE phase.
        DigitEn = 4'b1111; LeadZeroBlank = 1'b0; Value = 16'h8888;
        for (int i = 0; i < DIV && (k % DIV) != DIV/2; i++) step();
        #2 Rst = 1'b1;
        #1;
        check("async_an", 32'(An), 32'hF);
        check("async_seg", 32'(Seg), 32'h7F);
        check("async_dp", 32'(Dp), 32'h1);
        check("async_tick", 32'(ScanTick), 32'h0);
        @(negedge ClkIn);
        Rst = 1'b0;
        model_reset();
        run(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
